// File: rtl/spectro_pkg.sv
// Shared constants, FSM encoding and slot/bank mapping helpers for the spectrogram
// write and read paths.
package spectro_pkg;
  localparam int NO_BANKS       = 2;
  localparam int NO_FFTS        = 8;
  localparam int BINS           = 128;
  localparam int DATA_W         = 8;
  localparam int RAM_ADDR_WIDTH = 12;
  localparam int FPB            = NO_FFTS / NO_BANKS;
  localparam int SLOT_W         = $clog2(NO_FFTS);
  localparam int BIN_W          = (BINS > 1) ? $clog2(BINS) : 1;
  localparam int FILL_W         = SLOT_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP, ST_COMMIT} wr_state_e;

  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] slot);
    return (slot == SLOT_W'(NO_FFTS-1)) ? '0 : slot + SLOT_W'(1);
  endfunction

  function automatic logic [NO_BANKS-1:0] bank_onehot(input logic [SLOT_W-1:0] slot);
    return NO_BANKS'(1) << (int'(slot) / FPB);
  endfunction

  // Bank-local address is {slot within bank, bin}.
  function automatic logic [RAM_ADDR_WIDTH-1:0] ram_addr(input logic [SLOT_W-1:0] slot,
                                                         input logic [BIN_W-1:0]  bin);
    return RAM_ADDR_WIDTH'((int'(slot) % FPB) * BINS + int'(bin));
  endfunction
endpackage

// File: rtl/fft_frame_writer_if.sv
// Bin stream from the FFT magnitude stage into the frame writer.
interface fft_frame_writer_if;
  import spectro_pkg::*;
  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/slot_ring_ctrl.sv
// Circular slot bookkeeping: write slot, committed-frame count and the display's
// wrap origin, all advanced together on a commit pulse.
module slot_ring_ctrl
  import spectro_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [SLOT_W-1:0] oldest_fft_idx,
  output logic [FILL_W-1:0] fill_count
);
  logic [SLOT_W-1:0] slot_nx;
  logic [FILL_W-1:0] fill_nx;

  always_comb begin
    slot_nx = slot_next(wr_slot);
    fill_nx = (fill_count == FILL_W'(NO_FFTS-1)) ? fill_count : fill_count + FILL_W'(1);
  end

  // Saturating at NO_FFTS-1 keeps the slot being written outside the published window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_slot        <= '0;
      fill_count     <= '0;
      oldest_fft_idx <= '0;
    end else if (commit) begin
      wr_slot        <= slot_nx;
      fill_count     <= fill_nx;
      oldest_fft_idx <= (fill_nx == FILL_W'(NO_FFTS-1)) ? slot_next(slot_nx) : '0;
    end
  end
endmodule

// File: rtl/fft_frame_writer.sv
// Writes framed FFT magnitude bins into a circular set of slots across banked RAM;
// malformed frames are flagged and never committed.
module fft_frame_writer
  import spectro_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  fft_frame_writer_if.slave         s,
  input  logic                      freeze,
  output logic                      wr_en,
  output logic [NO_BANKS-1:0]       wr_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_W-1:0]         wr_data,
  output logic [SLOT_W-1:0]         oldest_fft_idx,
  output logic [FILL_W-1:0]         fill_count,
  output logic                      frame_err
);
  wr_state_e        state;
  logic [BIN_W-1:0] bin_cnt;
  logic [SLOT_W-1:0] wr_slot;
  logic             ready_q;
  logic             accept, at_end, commit;

  assign s.ready = ready_q;
  assign accept  = s.valid && ready_q;
  assign at_end  = (bin_cnt == BIN_W'(BINS-1));
  assign commit  = (state == ST_COMMIT);

  slot_ring_ctrl u_ring (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit         (commit),
    .wr_slot        (wr_slot),
    .oldest_fft_idx (oldest_fft_idx),
    .fill_count     (fill_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ready_q        <= 1'b0;
      bin_cnt        <= '0;
      wr_en          <= 1'b0;
      wr_bank_select <= '0;
      wr_address     <= '0;
      wr_data        <= '0;
      frame_err      <= 1'b0;
    end else begin
      wr_en          <= 1'b0;
      wr_bank_select <= '0;
      frame_err      <= 1'b0;
      ready_q        <= 1'b1;
      case (state)
        ST_IDLE, ST_WRITE: if (accept) begin
          // freeze only matters on the first beat; mid-frame it is ignored.
          if (state == ST_IDLE && freeze) begin
            if (!s.last) state <= ST_DROP;
          end else if (at_end && !s.last) begin
            frame_err <= 1'b1;
            state     <= ST_DROP;
          end else begin
            wr_en          <= 1'b1;
            wr_bank_select <= bank_onehot(wr_slot);
            wr_address     <= ram_addr(wr_slot, bin_cnt);
            wr_data        <= s.data;
            if (s.last) begin
              bin_cnt <= '0;
              if (at_end) begin
                state   <= ST_COMMIT;
                ready_q <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
              end
            end else begin
              bin_cnt <= bin_cnt + BIN_W'(1);
              state   <= ST_WRITE;
            end
          end
        end
        ST_DROP: if (accept && s.last) begin
          state   <= ST_IDLE;
          bin_cnt <= '0;
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_writer.sv
// Scoreboard bench for fft_frame_writer: expected RAM writes are queued as beats are
// driven and matched against wr_* as they appear.
module tb_fft_frame_writer;
  import spectro_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      freeze = 1'b0;
  logic                      wr_en;
  logic [NO_BANKS-1:0]       wr_bank_select;
  logic [RAM_ADDR_WIDTH-1:0] wr_address;
  logic [DATA_W-1:0]         wr_data;
  logic [SLOT_W-1:0]         oldest_fft_idx;
  logic [FILL_W-1:0]         fill_count;
  logic                      frame_err;

  fft_frame_writer_if bus();

  fft_frame_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s              (bus),
    .freeze         (freeze),
    .wr_en          (wr_en),
    .wr_bank_select (wr_bank_select),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .oldest_fft_idx (oldest_fft_idx),
    .fill_count     (fill_count),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NO_BANKS-1:0]       sel;
    logic [RAM_ADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]         data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0, n_fail = 0, err_seen = 0;
  bit  mon_on = 1'b0;
  int  m_slot = 0, m_fill = 0, m_oldest = 0;

  task automatic monitor();
    wr_t got, exp;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (frame_err) err_seen++;
        n_cmp++;
        if (wr_en) begin
          got = {wr_bank_select, wr_address, wr_data};
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected got=%h required=no write", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL wr_beat got sel=%b addr=%0d data=%0d required sel=%b addr=%0d data=%0d",
                       got.sel, got.addr, got.data, exp.sel, exp.addr, exp.data);
            end
          end
        end else if (wr_bank_select !== '0) begin
          n_fail++;
          $display("FAIL sel_idle got=%b required=0", wr_bank_select);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input logic [DATA_W-1:0] d, input bit last, input bit frz,
                      input bit expw, input int bc);
    int  guard = 0;
    wr_t e;
    bus.valid = 1'b1; bus.data = d; bus.last = last; freeze = frz;
    while (bus.ready !== 1'b1 && guard < 16) begin @(negedge clk); guard++; end
    if (guard >= 16) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout got=%b required=1", bus.ready);
    end
    if (expw) begin
      e.sel  = NO_BANKS'(1) << (m_slot / FPB);
      e.addr = RAM_ADDR_WIDTH'((m_slot % FPB) * BINS + bc);
      e.data = d;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int nbeats, input bit frz_start,
                           input int frz_mid);
    int  bc = 0, exp_err = 0, err0;
    bit  dropping, commit = 1'b0, last, expw, frz;
    err0 = err_seen;
    dropping = frz_start;
    for (int i = 0; i < nbeats; i++) begin
      last = (i == nbeats - 1);
      frz  = (frz_start && i == 0) || (frz_mid >= 0 && i >= frz_mid);
      expw = 1'b0;
      if (!dropping) begin
        if (bc == BINS - 1 && !last) begin
          exp_err++; dropping = 1'b1;
        end else begin
          expw = 1'b1;
          if (last) begin
            if (bc == BINS - 1) commit = 1'b1; else exp_err++;
          end
        end
      end
      beat(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)), last, frz, expw, bc);
      if (expw) bc++;
    end
    bus.valid = 1'b0; bus.last = 1'b0; freeze = 1'b0;
    if (commit) begin
      n_cmp++;
      if (bus.ready !== 1'b0) begin
        n_fail++; $display("FAIL %s ready_in_commit got=%b required=0", name, bus.ready);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.ready !== 1'b1) begin
        n_fail++; $display("FAIL %s ready_after_commit got=%b required=1", name, bus.ready);
      end
      m_slot   = (m_slot + 1) % NO_FFTS;
      m_fill   = (m_fill < NO_FFTS - 1) ? m_fill + 1 : m_fill;
      m_oldest = (m_fill == NO_FFTS - 1) ? (m_slot + 1) % NO_FFTS : 0;
    end else @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (err_seen - err0 !== exp_err) begin
      n_fail++; $display("FAIL %s frame_err_count got=%0d required=%0d", name, err_seen - err0, exp_err);
    end
    n_cmp++;
    if (fill_count !== FILL_W'(m_fill)) begin
      n_fail++; $display("FAIL %s fill_count got=%0d required=%0d", name, fill_count, m_fill);
    end
    n_cmp++;
    if (oldest_fft_idx !== SLOT_W'(m_oldest)) begin
      n_fail++; $display("FAIL %s oldest_fft_idx got=%0d required=%0d", name, oldest_fft_idx, m_oldest);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL %s missing_writes got=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.valid = 1'b0; bus.last = 1'b0; bus.data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wr_en, wr_bank_select, wr_address, wr_data, frame_err, bus.ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got en=%b sel=%b addr=%0d data=%0d err=%b rdy=%b required all 0",
                         wr_en, wr_bank_select, wr_address, wr_data, frame_err, bus.ready);
    end
    n_cmp++;
    if ({fill_count, oldest_fft_idx} !== '0) begin
      n_fail++; $display("FAIL reset_ring got fill=%0d oldest=%0d required 0", fill_count, oldest_fft_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ready got=%b required=1", bus.ready);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_clean_frame();
    run_frame("clean0", BINS, 1'b0, -1);
  endtask

  task automatic test_wrap();
    for (int f = 1; f < NO_FFTS; f++) run_frame("wrap", BINS, 1'b0, -1);
  endtask

  task automatic test_short_frame();
    run_frame("short61", 61, 1'b0, -1);
    run_frame("after_short", BINS, 1'b0, -1);
  endtask

  task automatic test_long_frame();
    run_frame("long200", 200, 1'b0, -1);
  endtask

  task automatic test_freeze();
    run_frame("freeze_start", BINS, 1'b1, -1);
    run_frame("freeze_mid", BINS, 1'b0, 40);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 50; i++) beat(DATA_W'(i), 1'b0, 1'b0, 1'b1, i);
    bus.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, wr_bank_select, wr_address, wr_data, frame_err, bus.ready, fill_count, oldest_fft_idx} !== '0) begin
      n_fail++; $display("FAIL async_reset got en=%b sel=%b addr=%0d fill=%0d oldest=%0d rdy=%b required all 0",
                         wr_en, wr_bank_select, wr_address, fill_count, oldest_fft_idx, bus.ready);
    end
    exp_q.delete();
    m_slot = 0; m_fill = 0; m_oldest = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("post_reset", BINS, 1'b0, -1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1);
  end

  initial begin
    fork monitor(); join_none
    test_reset();
    test_clean_frame();
    test_wrap();
    test_short_frame();
    test_long_frame();
    test_freeze();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_writer.md
Name: fft_frame_writer

Overview:
- Write-side counterpart of the display read path into the banked spectrogram RAM.
- Accepts a stream of FFT magnitude bins, one frame per FFT, and writes each frame into a circular set of NO_FFTS slots spread across NO_BANKS RAM banks.
- Publishes oldest_fft_idx, the slot index the display reader uses as its wrap origin.
- Sits between the FFT magnitude/scaling stage and the dual-port bank RAMs.

Parameters:
- NO_BANKS, 2: number of RAM banks; power of 2.
- NO_FFTS, 8: circular slot count; power of 2; multiple of NO_BANKS.
- BINS, 128: bins per FFT frame; power of 2.
- DATA_W, 8: magnitude width.
- RAM_ADDR_WIDTH, 12: bank address width; must be >= log2(NO_FFTS/NO_BANKS)+log2(BINS).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  bin valid.
- s_ready  out  1  bin accepted when s_valid&&s_ready.
- s_data  in  DATA_W  bin magnitude.
- s_last  in  1  marks final bin of frame.
- freeze  in  1  display hold; frames arriving while high are dropped.
- wr_en  out  1  RAM write strobe.
- wr_bank_select  out  NO_BANKS  one-hot bank enable; zero when wr_en low.
- wr_address  out  RAM_ADDR_WIDTH  bank-local address.
- wr_data  out  DATA_W  write data.
- oldest_fft_idx  out  $clog2(NO_FFTS)  oldest fully committed slot.
- fill_count  out  $clog2(NO_FFTS)+1  committed frames, saturates at NO_FFTS-1.
- frame_err  out  1  one-cycle pulse on malformed frame.

Behaviour:
- Reset (async, rst_n low): all outputs 0; wr_slot=0; bin_cnt=0; state=IDLE.
- FSM states:
  - IDLE: s_ready=1. On the first accepted beat, sample freeze: freeze=1 → DROP; else → WRITE, and that beat is written.
  - WRITE: s_ready=1; each accepted beat is written.
  - DROP: s_ready=1; beats are discarded, with no wr_en, until an accepted s_last, then → IDLE.
  - COMMIT: s_ready=0 for exactly 1 cycle, then → IDLE.
- Mapping of each written beat:
  - FPB = NO_FFTS/NO_BANKS.
  - bank = wr_slot / FPB; wr_bank_select = 1<<bank.
  - wr_address = zero-extend {wr_slot mod FPB, bin_cnt}.
  - wr_data = s_data.
- Write outputs are registered: 1-cycle latency from the accepting edge.
- bin_cnt increments per written beat and clears on entry to IDLE.
- Frame checks in WRITE:
  - Accepted s_last with bin_cnt==BINS-1 → COMMIT.
  - Accepted s_last with bin_cnt<BINS-1 → frame_err pulse, → IDLE, no commit.
  - Accepted beat with bin_cnt==BINS-1 and s_last=0 → frame_err pulse, → DROP. That beat is not written.
- In both error cases wr_slot, oldest_fft_idx and fill_count are unchanged; the next frame overwrites the same slot.
- COMMIT, all updated on the same edge:
  - wr_slot ← (wr_slot==NO_FFTS-1) ? 0 : wr_slot+1.
  - fill_count ← min(fill_count+1, NO_FFTS-1).
  - oldest_fft_idx ← (new fill_count==NO_FFTS-1) ? (new wr_slot+1) mod NO_FFTS : 0.
- The slot currently being written is never within the published window, so the display never shows a torn frame.
- freeze is only sampled at frame start. Asserting it mid-frame does not abort the frame.
- A 1-bin frame (s_last on the first beat) is malformed unless BINS==1.
- Reset mid-frame discards the partial frame. RAM contents are not cleared; fill_count=0 hides them.

Decomposition:
- Shared package (spectro_pkg):
  - Constants NO_BANKS, NO_FFTS, BINS, DATA_W, RAM_ADDR_WIDTH, FPB.
  - Derived widths SLOT_W, BIN_W.
  - FSM state enum.
  - Function slot_next(slot) for modulo increment; the display read mapper uses the same function.
- One natural sub-module, slot_ring_ctrl: owns wr_slot, fill_count and oldest_fft_idx, driven by a commit pulse. The top holds the FSM, bin_cnt and write register.

Test Plan:
- Reset, then one clean 128-beat frame, s_data=bin_cnt → wr_en high for 128 cycles; wr_bank_select=01; addresses 0..127; after COMMIT wr_slot=1, fill_count=1, oldest_fft_idx=0; s_ready low exactly 1 cycle.
- 8 clean frames → frame 4 (slot 4) writes bank 10 at addresses 0..127; after frame 7 fill_count=7, oldest_fft_idx=1; wrap puts wr_slot back to 0.
- Frame with s_last at beat 60 → frame_err pulses once; fill_count and wr_slot unchanged; next clean frame writes slot 0 addresses 0..127.
- 200-beat frame without s_last until beat 200 → frame_err at beat 128; no wr_en for beats 128..199; returns to IDLE after s_last; no commit.
- freeze=1 at frame start → zero wr_en for the whole frame. freeze=1 mid-frame → frame commits normally.
- rst_n pulsed low at beat 50 of a frame → outputs 0 immediately (async); the next frame writes slot 0 from address 0.
